// File: rtl/wc_tile_loader.sv
// Tile assembler feeding the Winograd F(5,3) core: packs a serial sample stream into
// overlapping 7-sample tiles (stride 5, overlap 2), zero-padding the last tile of a row.
module wc_tile_loader #(
    parameter int DW = 10,
    parameter int M  = 5,
    parameter int R  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_last,
    output logic                   tile_valid,
    input  logic                   tile_ready,
    output logic [DW*(M+R-1)-1:0]  tile_data,
    output logic [2:0]             tile_nvalid,
    output logic                   tile_last
);

    localparam int TILE = M + R - 1;
    localparam int OVL  = R - 1;
    localparam logic [2:0] TILE_CNT = 3'(TILE);
    localparam logic [2:0] OVL_CNT  = 3'(OVL);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    logic [DW-1:0] win [TILE];
    logic [2:0]    cnt;
    logic [2:0]    cnt_inc;
    logic          accept;
    logic          tile_done;
    logic          tile_take;

    assign cnt_inc = cnt + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // in_ready depends on state only, so tile_ready never reaches it combinationally
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        tile_valid = 1'b0;
        accept     = 1'b0;
        tile_done  = 1'b0;
        tile_take  = 1'b0;
        case (state)
            FILL: begin
                in_ready  = 1'b1;
                accept    = in_valid;
                tile_done = in_valid && ((cnt_inc == TILE_CNT) || in_last);
                if (tile_done) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                tile_valid = 1'b1;
                tile_take  = tile_ready;
                if (tile_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TILE; k++) begin
                win[k] <= '0;
            end
            cnt         <= 3'd0;
            tile_nvalid <= 3'd0;
            tile_last   <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < TILE; k++) begin
                if (3'(k) == cnt) begin
                    win[k] <= in_data;
                end
            end
            cnt <= cnt_inc;
            if (tile_done) begin
                tile_last   <= in_last;
                tile_nvalid <= cnt_inc;
            end
        end else if (tile_take) begin
            // Clear everything first; mid-row tiles then carry the overlap samples forward
            for (int k = 0; k < TILE; k++) begin
                win[k] <= '0;
            end
            if (tile_last) begin
                cnt <= 3'd0;
            end else begin
                for (int k = 0; k < OVL; k++) begin
                    win[k] <= win[k+M];
                end
                cnt <= OVL_CNT;
            end
        end
    end

    for (genvar k = 0; k < TILE; k++) begin : g_pack
        assign tile_data[DW*k +: DW] = win[k];
    end

endmodule

// File: tb/tb_wc_tile_loader.sv
// Scoreboard bench for wc_tile_loader: directed tile vectors plus a random stall run
// checked against an index-arithmetic model of the tiling.
module tb_wc_tile_loader;

    localparam int DW   = 10;
    localparam int TILE = 7;
    localparam int TW   = DW * TILE;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          tile_valid;
    logic          tile_ready;
    logic [TW-1:0] tile_data;
    logic [2:0]    tile_nvalid;
    logic          tile_last;

    always #5 clk = ~clk;

    wc_tile_loader #(.DW(DW), .M(5), .R(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .tile_valid  (tile_valid),
        .tile_ready  (tile_ready),
        .tile_data   (tile_data),
        .tile_nvalid (tile_nvalid),
        .tile_last   (tile_last)
    );

    typedef struct packed {
        logic [TW-1:0] data;
        logic [2:0]    nv;
        logic          last;
    } tile_t;

    tile_t sb[$];
    int    rowBuf[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    readyMode   = 1;
    bit    modelOn     = 1'b0;

    task automatic checkOutput(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] runTile(input int base, input int n);
        logic [TW-1:0] t;
        t = '0;
        for (int k = 0; k < n; k++) begin
            t[DW*k +: DW] = DW'(base + k);
        end
        return t;
    endfunction

    task automatic pushExp(input int base, input int n, input logic last);
        tile_t e;
        e.data = runTile(base, n);
        e.nv   = 3'(n);
        e.last = last;
        sb.push_back(e);
    endtask

    // Row index i closes a tile when full (i = 6, 11, 16, ...) or on in_last;
    // tiles start at multiples of 5 within the row
    task automatic modelAccept(input int d, input logic last);
        int    i;
        int    start;
        int    n;
        tile_t e;
        i = rowBuf.size();
        rowBuf.push_back(d);
        if ((i >= 6 && (i - 6) % 5 == 0) || last) begin
            start  = (i < 7) ? 0 : 5 * ((i - 2) / 5);
            n      = i - start + 1;
            e.data = '0;
            for (int k = 0; k < n; k++) begin
                e.data[DW*k +: DW] = DW'(rowBuf[start+k]);
            end
            e.nv   = 3'(n);
            e.last = last;
            sb.push_back(e);
        end
        if (last) begin
            rowBuf.delete();
        end
    endtask

    // Caller is at a negedge; returns at a negedge after the sample is accepted
    task automatic applyStimulus(input int d, input logic last);
        int budget;
        in_data  = DW'(d);
        in_last  = last;
        in_valid = 1'b1;
        budget   = 500;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout: sample %0d never accepted, in_ready=%0b, expected 1", d, in_ready);
        end else begin
            @(posedge clk);
            if (modelOn) modelAccept(d, last);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        rowBuf.delete();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"},   TW'(in_ready),    TW'(1));
        checkOutput({tag, "_tile_valid"}, TW'(tile_valid),  TW'(0));
        checkOutput({tag, "_tile_data"},  tile_data,        '0);
        checkOutput({tag, "_tile_nvalid"},TW'(tile_nvalid), TW'(0));
        checkOutput({tag, "_tile_last"},  TW'(tile_last),   TW'(0));
    endtask

    task automatic waitDrain(input string tag);
        int budget;
        budget = 2000;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput({tag, "_drain_pending"}, TW'(sb.size()), TW'(0));
        @(negedge clk);
    endtask

    // Monitor: chooses tile_ready each cycle and scores every tile handshake
    initial begin
        tile_t e;
        tile_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       tile_ready = 1'b0;
                1:       tile_ready = 1'b1;
                default: tile_ready = 1'($urandom_range(0, 1));
            endcase
            if (tile_valid && tile_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_tile: got data %0h nvalid %0d, expected no tile", tile_data, tile_nvalid);
                end else begin
                    e = sb.pop_front();
                    checkOutput("tile_data",   tile_data,         e.data);
                    checkOutput("tile_nvalid", TW'(tile_nvalid),  TW'(e.nv));
                    checkOutput("tile_last",   TW'(tile_last),    TW'(e.last));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetState("reset");

        $display("[TB] test 1: continuous stream 1..12");
        readyMode = 1;
        pushExp(1, 7, 1'b0);
        pushExp(6, 7, 1'b0);
        for (int v = 1; v <= 12; v++) applyStimulus(v, 1'b0);
        waitDrain("t1");

        $display("[TB] test 2: row end with padding");
        doReset();
        pushExp(1, 7, 1'b0);
        pushExp(6, 4, 1'b1);
        pushExp(100, 1, 1'b1);
        for (int v = 1; v <= 9; v++) applyStimulus(v, v == 9);
        applyStimulus(100, 1'b1);
        waitDrain("t2");

        $display("[TB] test 3: backpressure");
        doReset();
        readyMode = 0;
        pushExp(1, 7, 1'b0);
        pushExp(6, 7, 1'b0);
        for (int v = 1; v <= 7; v++) applyStimulus(v, 1'b0);
        in_data  = DW'(8);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_in_ready",   TW'(in_ready),   TW'(0));
            checkOutput("bp_tile_valid", TW'(tile_valid), TW'(1));
            checkOutput("bp_tile_data",  tile_data,       runTile(1, 7));
            @(negedge clk);
        end
        readyMode = 1;
        for (int v = 8; v <= 12; v++) applyStimulus(v, 1'b0);
        waitDrain("t3");

        $display("[TB] test 4: in_last on a full tile");
        doReset();
        pushExp(1, 7, 1'b1);
        pushExp(20, 7, 1'b0);
        pushExp(25, 3, 1'b1);
        for (int v = 1; v <= 7; v++) applyStimulus(v, v == 7);
        for (int v = 20; v <= 26; v++) applyStimulus(v, 1'b0);
        applyStimulus(27, 1'b1);
        waitDrain("t4");

        $display("[TB] test 5: reset in HOLD and mid-FILL");
        doReset();
        readyMode = 0;
        for (int v = 1; v <= 7; v++) applyStimulus(v, 1'b0);
        checkOutput("hold_tile_valid", TW'(tile_valid), TW'(1));
        doReset();
        checkResetState("rst_hold");
        for (int v = 11; v <= 14; v++) applyStimulus(v, 1'b0);
        doReset();
        checkResetState("rst_fill");
        readyMode = 1;
        pushExp(31, 7, 1'b0);
        for (int v = 31; v <= 37; v++) applyStimulus(v, 1'b0);
        waitDrain("t5");

        $display("[TB] test 6: random stalls against model");
        doReset();
        modelOn   = 1'b1;
        readyMode = 2;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(int'($urandom_range(0, 1023)), $urandom_range(0, 14) == 0);
        end
        applyStimulus(5, 1'b1);
        readyMode = 1;
        waitDrain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
